// File: rtl/vx_raster_stamp_dispatch.sv
// Raster stamp dispatcher: serves a warp fetch request by filling one active lane
// per cycle from the rasterizer stamp stream, then holds the response until it is taken.
module vx_raster_stamp_dispatch #(
  parameter int NUM_LANES = 4,
  parameter int NUM_WARPS = 4,
  parameter int DIM_BITS  = 15,
  parameter int PID_BITS  = 16,
  localparam int WID_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  localparam int POS_BITS   = DIM_BITS - 1,
  localparam int BCO_BITS   = 4 * 3 * 32,
  localparam int PM_BITS    = 2 * POS_BITS + 4,
  localparam int STAMP_BITS = 2 * POS_BITS + 4 + BCO_BITS + PID_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stamp_valid,
  input  logic [STAMP_BITS-1:0]         stamp_data,
  input  logic                          stamp_done,
  output logic                          stamp_ready,
  input  logic                          req_valid,
  input  logic [WID_BITS-1:0]           req_wid,
  input  logic [NUM_LANES-1:0]          req_tmask,
  output logic                          req_ready,
  output logic                          rsp_valid,
  output logic [WID_BITS-1:0]           rsp_wid,
  output logic [NUM_LANES-1:0]          rsp_tmask,
  output logic [NUM_LANES*32-1:0]       rsp_pos_mask,
  output logic [NUM_LANES*BCO_BITS-1:0] rsp_bcoords,
  output logic [NUM_LANES*PID_BITS-1:0] rsp_pid,
  input  logic                          rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e               state_r;
  state_e               next_state_s;
  logic [WID_BITS-1:0]  wid_r;
  logic [NUM_LANES-1:0] tmask_r;
  logic [NUM_LANES-1:0] filled_r;
  logic [NUM_LANES-1:0] pending_s;
  logic [NUM_LANES-1:0] sel_s;
  logic [NUM_LANES-1:0] remain_s;
  logic                 accept_s;
  logic                 fill_s;
  logic [31:0]          pm_s;

  logic [31:0]          pos_mask_r [NUM_LANES];
  logic [BCO_BITS-1:0]  bcoords_r  [NUM_LANES];
  logic [PID_BITS-1:0]  pid_r      [NUM_LANES];

  assign accept_s  = (state_r == IDLE) && req_valid;
  assign pending_s = tmask_r & ~filled_r;
  assign remain_s  = pending_s & ~sel_s;

  // Lowest-indexed active lane still waiting for data.
  always_comb begin
    sel_s = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (pending_s[i]) begin
        sel_s    = '0;
        sel_s[i] = 1'b1;
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Lane position word {pos_y, pos_x, mask}, zero-extended to 32 bits.
  always_comb begin
    pm_s = '0;
    pm_s[PM_BITS-1:0] = {stamp_data[STAMP_BITS-1-POS_BITS -: POS_BITS],
                         stamp_data[STAMP_BITS-1 -: POS_BITS],
                         stamp_data[PID_BITS+BCO_BITS +: 4]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a lane is filled by a stamp or, once geometry is exhausted, by a zero marker.
  always_comb begin
    next_state_s = state_r;
    fill_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          next_state_s = (req_tmask != '0) ? FILL : RSP;
        end else begin
          next_state_s = IDLE;
        end
      end
      FILL: begin
        if (stamp_valid || stamp_done) begin
          fill_s       = 1'b1;
          next_state_s = (remain_s == '0) ? RSP : FILL;
        end else begin
          next_state_s = FILL;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RSP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Request latch and per-lane response data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wid_r    <= '0;
      tmask_r  <= '0;
      filled_r <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        pos_mask_r[i] <= 32'd0;
        bcoords_r[i]  <= '0;
        pid_r[i]      <= '0;
      end
    end else if (accept_s) begin
      wid_r    <= req_wid;
      tmask_r  <= req_tmask;
      filled_r <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        pos_mask_r[i] <= 32'd0;
        bcoords_r[i]  <= '0;
        pid_r[i]      <= '0;
      end
    end else if (fill_s) begin
      filled_r <= filled_r | sel_s;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (sel_s[i] && stamp_valid) begin
          pos_mask_r[i] <= pm_s;
          bcoords_r[i]  <= stamp_data[PID_BITS +: BCO_BITS];
          pid_r[i]      <= stamp_data[PID_BITS-1:0];
        end else if (sel_s[i]) begin
          pos_mask_r[i] <= 32'd0;
          bcoords_r[i]  <= '0;
          pid_r[i]      <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign rsp_pos_mask[g*32 +: 32]           = pos_mask_r[g];
    assign rsp_bcoords[g*BCO_BITS +: BCO_BITS] = bcoords_r[g];
    assign rsp_pid[g*PID_BITS +: PID_BITS]     = pid_r[g];
  end

  assign req_ready   = (state_r == IDLE) && !reset;
  assign stamp_ready = (state_r == FILL) && !reset;
  assign rsp_valid   = (state_r == RSP) && !reset;
  assign rsp_wid     = wid_r;
  assign rsp_tmask   = tmask_r;

endmodule
